mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 9 +
 rtl/mem_arbiter.sv | 107 ++++++++++
 2 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port (fetch/data) memory arbiter.
package mem_arb_pkg;

  localparam int WAIT_W = 4;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates fetch (i) and data (d) requesters onto one memory port, one
// outstanding transaction at a time; data has priority with a fetch anti-starvation limit.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              stray_rvalid,
  output logic              dbg_state,
  output logic [WAIT_W-1:0] dbg_wait_cnt
);

  // Handshake: a request transfers on the cycle where req and gnt are both
  // high; the requester holds req and its fields stable until then. A response
  // is the single cycle where rvalid is high; there is no back-pressure on it.

  state_t            state;
  owner_t            owner;
  logic [WAIT_W-1:0] wait_cnt;

  logic idle, sel_i, req_any, hs, i_win, d_win, resp;

  always_comb begin
    idle    = (state == IDLE);
    sel_i   = i_req && (!d_req || (wait_cnt == WAIT_W'(MAX_WAIT)));
    req_any = idle && (i_req || d_req);
    hs      = req_any && mem_gnt;
    i_win   = hs && sel_i;
    d_win   = hs && !sel_i;
    resp    = (state == BUSY) && mem_rvalid;
  end

  // Outputs are additionally qualified by rst_n so they read 0 while reset is held.
  always_comb begin
    mem_req      = rst_n && req_any;
    mem_we       = mem_req && !sel_i && d_we;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_wstrb    = '0;
    if (mem_req) begin
      mem_addr  = sel_i ? i_addr : d_addr;
      mem_wdata = sel_i ? 32'h0 : d_wdata;
      mem_wstrb = sel_i ? 4'h0 : d_wstrb;
    end
    i_gnt        = rst_n && i_win;
    d_gnt        = rst_n && d_win;
    i_rvalid     = resp && (owner == OWN_I);
    d_rvalid     = resp && (owner == OWN_D);
    i_rdata      = i_rvalid ? mem_rdata : 32'h0;
    d_rdata      = d_rvalid ? mem_rdata : 32'h0;
    stray_rvalid = rst_n && idle && mem_rvalid;
    dbg_state    = state;
    dbg_wait_cnt = wait_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= OWN_D;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            owner <= sel_i ? OWN_I : OWN_D;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (mem_rvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Counts data wins that starved a pending fetch; saturates at MAX_WAIT.
      if (!i_req || i_win)
        wait_cnt <= '0;
      else if (d_win && (wait_cnt != WAIT_W'(MAX_WAIT)))
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule
